// File: rtl/kf_cfg_sequencer_pkg.sv
// ============================================================================
// kf_cfg_sequencer_pkg : shared types and constants for the config sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package kf_cfg_sequencer_pkg;

    localparam int KF_NEURON_ID_BITS   = 10;
    localparam int KF_SYNAPSE_ID_BITS  = 12;
    localparam int KF_CFG_QUIET_CYCLES = 2;

    typedef struct packed {
        logic [1:0]                    sel;
        logic [KF_SYNAPSE_ID_BITS-1:0] addr;
        logic [31:0]                   wdata;
        logic                          last;
    } kf_cfg_cmd_t;

    typedef enum logic [2:0] {
        CFGSEQ_IDLE   = 3'd0,
        CFGSEQ_DRAIN  = 3'd1,
        CFGSEQ_WRITE  = 3'd2,
        CFGSEQ_SETTLE = 3'd3,
        CFGSEQ_FLUSH  = 3'd4
    } kf_cfgseq_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kf_cfg_sequencer_if.sv
// ============================================================================
// kf_spike_if / kf_cfg_cmd_if : spike stream and config command handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

interface kf_spike_if;
    import kf_cfg_sequencer_pkg::*;

    logic                         valid;
    logic                         ready;
    logic [KF_NEURON_ID_BITS-1:0] pre_id;
    logic [7:0]                   payload;

    modport master (output valid, output pre_id, output payload, input ready);
    modport slave  (input valid, input pre_id, input payload, output ready);
endinterface

interface kf_cfg_cmd_if;
    import kf_cfg_sequencer_pkg::*;

    logic        valid;
    logic        ready;
    kf_cfg_cmd_t cmd;

    modport master (output valid, output cmd, input ready);
    modport slave  (input valid, input cmd, output ready);
endinterface

`default_nettype wire

// File: rtl/kf_cfg_sequencer_spike_gate.sv
// ============================================================================
// kf_spike_gate : valid/ready gate between router local port and core input
// Rev 1.0
// ============================================================================
`default_nettype none

module kf_spike_gate (
    input  logic       gate_req,
    output logic       safe_to_close,
    kf_spike_if.slave  up,
    kf_spike_if.master dn
);

    // Closing is only glitch-free when no spike is mid-handshake; the
    // controller waits for safe_to_close before raising gate_req.
    assign safe_to_close = !(up.valid && !dn.ready);

    assign dn.valid   = up.valid && !gate_req;
    assign up.ready   = dn.ready && !gate_req;
    assign dn.pre_id  = up.pre_id;
    assign dn.payload = up.payload;

endmodule

`default_nettype wire

// File: rtl/kf_cfg_sequencer.sv
// ============================================================================
// kf_cfg_sequencer : quiesces spike ingress, drains the core, issues config
// Rev 1.0
// ============================================================================
`default_nettype none

module kf_cfg_sequencer
    import kf_cfg_sequencer_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    kf_cfg_cmd_if.slave                   cmd,
    kf_spike_if.slave                     up,
    kf_spike_if.master                    dn,
    input  logic                          core_busy,
    output logic                          cfg_we,
    output logic [1:0]                    cfg_sel,
    output logic [KF_SYNAPSE_ID_BITS-1:0] cfg_addr,
    output logic [31:0]                   cfg_wdata,
    output logic                          cfg_active,
    output logic                          cfg_done,
    output logic                          cfg_error,
    output logic [15:0]                   write_count
);

    localparam int DRAIN_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int QUIET_W  = $clog2(KF_CFG_QUIET_CYCLES);

    localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [QUIET_W-1:0]  QUIET_LAST  = QUIET_W'(KF_CFG_QUIET_CYCLES - 1);

    kf_cfgseq_state_t    state;
    kf_cfgseq_state_t    state_nxt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [QUIET_W-1:0]  quiet_cnt;
    logic                safe_to_close;
    logic                cmd_rdy;
    logic                go_drain;
    logic                drain_expired;
    logic                accept;

    kf_spike_gate u_gate (
        .gate_req      (cfg_active),
        .safe_to_close (safe_to_close),
        .up            (up),
        .dn            (dn)
    );

    assign cmd.ready = cmd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CFGSEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_rdy       = 1'b0;
        go_drain      = 1'b0;
        drain_expired = 1'b0;
        accept        = 1'b0;
        cfg_active    = (state != CFGSEQ_IDLE);
        cfg_done      = 1'b0;
        case (state)
            CFGSEQ_IDLE: begin
                if (cmd.valid && safe_to_close) begin
                    state_nxt = CFGSEQ_DRAIN;
                    go_drain  = 1'b1;
                end
            end
            CFGSEQ_DRAIN: begin
                // A completed quiet window wins over a timeout in the same cycle.
                if (!core_busy && quiet_cnt == QUIET_LAST) begin
                    state_nxt = CFGSEQ_WRITE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = CFGSEQ_FLUSH;
                    drain_expired = 1'b1;
                end
            end
            CFGSEQ_WRITE: begin
                cmd_rdy = 1'b1;
                if (cmd.valid) begin
                    accept = 1'b1;
                    if (cmd.cmd.last) begin
                        state_nxt = CFGSEQ_SETTLE;
                    end
                end
            end
            CFGSEQ_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    cfg_done  = 1'b1;
                    state_nxt = CFGSEQ_IDLE;
                end
            end
            CFGSEQ_FLUSH: begin
                cmd_rdy = 1'b1;
                if (cmd.valid && cmd.cmd.last) begin
                    state_nxt = CFGSEQ_IDLE;
                end
            end
            default: begin
                state_nxt = CFGSEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_we      <= 1'b0;
            cfg_sel     <= '0;
            cfg_addr    <= '0;
            cfg_wdata   <= '0;
            cfg_error   <= 1'b0;
            write_count <= '0;
            drain_cnt   <= '0;
            settle_cnt  <= '0;
            quiet_cnt   <= '0;
        end else begin
            cfg_we <= accept;
            if (accept) begin
                cfg_sel     <= cmd.cmd.sel;
                cfg_addr    <= cmd.cmd.addr;
                cfg_wdata   <= cmd.cmd.wdata;
                write_count <= sat_inc16(write_count);
            end else if (go_drain) begin
                write_count <= '0;
            end

            if (go_drain) begin
                cfg_error <= 1'b0;
            end else if (drain_expired) begin
                cfg_error <= 1'b1;
            end

            drain_cnt  <= (state == CFGSEQ_DRAIN)  ? drain_cnt + DRAIN_W'(1)   : '0;
            settle_cnt <= (state == CFGSEQ_SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
            quiet_cnt  <= (state == CFGSEQ_DRAIN && !core_busy) ? quiet_cnt + QUIET_W'(1) : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kf_cfg_sequencer.sv
// ============================================================================
// tb_kf_cfg_sequencer : directed self-checking bench for kf_cfg_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_kf_cfg_sequencer;
    import kf_cfg_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    logic core_busy;
    logic cfg_we;
    logic [1:0] cfg_sel;
    logic [KF_SYNAPSE_ID_BITS-1:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic cfg_active;
    logic cfg_done;
    logic cfg_error;
    logic [15:0] write_count;

    kf_cfg_cmd_if cmd_if ();
    kf_spike_if   up_if ();
    kf_spike_if   dn_if ();

    kf_cfg_sequencer #(
        .DRAIN_TIMEOUT (16),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd_if),
        .up          (up_if),
        .dn          (dn_if),
        .core_busy   (core_busy),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_active  (cfg_active),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error),
        .write_count (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    kf_cfg_cmd_t cmds [8];
    int   busy_pat [8];
    int   busy_len;
    logic busy_rest;

    int n_we, n_done, done_cyc, dnv_act, upr_act, err_first, err_last, last_act, consumed;
    int we_cyc [8];
    logic [1:0]                    we_sel   [8];
    logic [KF_SYNAPSE_ID_BITS-1:0] we_addr  [8];
    logic [31:0]                   we_wdata [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Presents cmds[0..n-1] from cycle 0 (entered at posedge+1) and logs
    // DUT activity for max_cyc cycles; returns at posedge+1 after the last.
    task automatic run_batch(input int n, input int max_cyc);
        int  idx;
        bit  take;
        idx = 0;
        n_we = 0; n_done = 0; done_cyc = -1; dnv_act = 0; upr_act = 0;
        err_first = -1; err_last = -1; last_act = -1;
        cmd_if.valid = 1'b1;
        cmd_if.cmd   = cmds[0];
        core_busy    = (busy_len > 0) ? busy_pat[0][0] : busy_rest;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (cfg_we && n_we < 8) begin
                we_cyc[n_we]   = cyc;
                we_sel[n_we]   = cfg_sel;
                we_addr[n_we]  = cfg_addr;
                we_wdata[n_we] = cfg_wdata;
                n_we++;
            end
            if (cfg_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (cfg_active) begin
                last_act = cyc;
                if (dn_if.valid) dnv_act++;
                if (up_if.ready) upr_act++;
            end
            if (cfg_error) begin
                if (err_first < 0) err_first = cyc;
                err_last = cyc;
            end
            take = cmd_if.valid && cmd_if.ready;
            @(posedge clk);
            #1;
            if (take) begin
                idx++;
                if (idx < n) cmd_if.cmd = cmds[idx];
                else         cmd_if.valid = 1'b0;
            end
            core_busy = (cyc + 1 < busy_len) ? busy_pat[cyc + 1][0] : busy_rest;
        end
        consumed = idx;
    endtask

    task automatic check_we(input string tag, input int k);
        check({tag, "_sel"},   64'(we_sel[k]),   64'(cmds[k].sel));
        check({tag, "_addr"},  64'(we_addr[k]),  64'(cmds[k].addr));
        check({tag, "_wdata"}, 64'(we_wdata[k]), 64'(cmds[k].wdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int xfers;
        int we_after;
        logic rdy;

        // ---------------- reset values, passthrough during reset ----------
        rst_n = 1'b0;
        core_busy = 1'b0;
        cmd_if.valid = 1'b0;
        cmd_if.cmd = '0;
        up_if.valid = 1'b1;
        up_if.pre_id = 10'h2A;
        up_if.payload = 8'h11;
        dn_if.ready = 1'b0;
        busy_len = 0;
        busy_rest = 1'b0;
        #12;
        check("rst_dn_valid",    64'(dn_if.valid), 64'd1);
        check("rst_up_ready",    64'(up_if.ready), 64'd0);
        check("rst_cmd_ready",   64'(cmd_if.ready), 64'd0);
        check("rst_cfg_we",      64'(cfg_we), 64'd0);
        check("rst_cfg_fields",  64'({cfg_sel, cfg_addr, cfg_wdata}), 64'd0);
        check("rst_cfg_active",  64'(cfg_active), 64'd0);
        check("rst_cfg_done",    64'(cfg_done), 64'd0);
        check("rst_cfg_error",   64'(cfg_error), 64'd0);
        check("rst_write_count", 64'(write_count), 64'd0);
        dn_if.ready = 1'b1;
        #1;
        check("rst_up_ready_follow", 64'(up_if.ready), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- idle passthrough, random dn_ready ----------------
        sent = 0;
        xfers = 0;
        for (int g = 0; g < 100 && sent < 8; g++) begin
            rdy = 1'($urandom_range(0, 1));
            dn_if.ready   = rdy;
            up_if.valid   = 1'b1;
            up_if.pre_id  = 10'(sent * 37 + 3);
            up_if.payload = 8'(sent * 17 + 1);
            @(negedge clk);
            check("pt_valid",     64'(dn_if.valid), 64'd1);
            check("pt_ready",     64'(up_if.ready), 64'(rdy));
            check("pt_pre_id",    64'(dn_if.pre_id), 64'(sent * 37 + 3));
            check("pt_payload",   64'(dn_if.payload), 64'(8'(sent * 17 + 1)));
            check("pt_cmd_ready", 64'(cmd_if.ready), 64'd0);
            if (dn_if.valid && dn_if.ready) xfers++;
            @(posedge clk); #1;
            if (rdy) sent++;
        end
        check("pt_delivered", 64'(xfers), 64'd8);

        // ---------------- three-command batch ----------------
        up_if.valid = 1'b1;
        dn_if.ready = 1'b1;
        cmds[0] = '{sel: 2'd0, addr: 12'd5, wdata: 32'hA5A5_0001, last: 1'b0};
        cmds[1] = '{sel: 2'd1, addr: 12'd6, wdata: 32'hA5A5_0002, last: 1'b0};
        cmds[2] = '{sel: 2'd2, addr: 12'd7, wdata: 32'hA5A5_0003, last: 1'b1};
        run_batch(3, 10);
        check("b3_consumed", 64'(consumed), 64'd3);
        check("b3_n_we",     64'(n_we), 64'd3);
        check("b3_we0_cyc",  64'(we_cyc[0]), 64'd4);
        check("b3_we2_cyc",  64'(we_cyc[2]), 64'd6);
        check_we("b3_we0", 0);
        check_we("b3_we1", 1);
        check_we("b3_we2", 2);
        check("b3_write_count", 64'(write_count), 64'd3);
        check("b3_n_done",   64'(n_done), 64'd1);
        check("b3_done_cyc", 64'(done_cyc), 64'd7);
        check("b3_last_act", 64'(last_act), 64'd7);
        check("b3_dn_valid_gated", 64'(dnv_act), 64'd0);
        check("b3_up_ready_gated", 64'(upr_act), 64'd0);
        check("b3_cfg_error", 64'(cfg_error), 64'd0);

        // ---------------- stalled spike at command arrival ----------------
        cmds[0] = '{sel: 2'd3, addr: 12'd9, wdata: 32'h1234_5678, last: 1'b1};
        up_if.valid   = 1'b1;
        up_if.pre_id  = 10'h155;
        up_if.payload = 8'h3C;
        dn_if.ready   = 1'b0;
        cmd_if.valid  = 1'b1;
        cmd_if.cmd    = cmds[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_active", 64'(cfg_active), 64'd0);
            check("stall_dn_valid", 64'(dn_if.valid), 64'd1);
            check("stall_pre_id", 64'(dn_if.pre_id), 64'h155);
            @(posedge clk); #1;
        end
        dn_if.ready = 1'b1;
        @(negedge clk);
        check("stall_xfer_ready", 64'(up_if.ready), 64'd1);
        check("stall_xfer_idle",  64'(cfg_active), 64'd0);
        @(posedge clk); #1;
        check("stall_then_drain", 64'(cfg_active), 64'd1);
        check("stall_gated",      64'(dn_if.valid), 64'd0);
        up_if.valid = 1'b0;
        run_batch(1, 8);
        check("one_n_we",    64'(n_we), 64'd1);
        check("one_we_cyc",  64'(we_cyc[0]), 64'd3);
        check_we("one_we0", 0);
        check("one_done_cyc", 64'(done_cyc), 64'd4);
        check("one_write_count", 64'(write_count), 64'd1);

        // ---------------- drain timeout, busy held high ----------------
        cmds[0] = '{sel: 2'd1, addr: 12'd20, wdata: 32'hDEAD_0001, last: 1'b0};
        cmds[1] = '{sel: 2'd2, addr: 12'd21, wdata: 32'hDEAD_0002, last: 1'b1};
        busy_len = 0;
        busy_rest = 1'b1;
        run_batch(2, 24);
        check("to_err_first",  64'(err_first), 64'd17);
        check("to_consumed",   64'(consumed), 64'd2);
        check("to_n_we",       64'(n_we), 64'd0);
        check("to_n_done",     64'(n_done), 64'd0);
        check("to_last_act",   64'(last_act), 64'd18);
        check("to_write_count", 64'(write_count), 64'd0);
        check("to_cfg_error",  64'(cfg_error), 64'd1);

        // ---------------- busy glitch 0,1,0,0 in DRAIN; error clears -------
        cmds[0] = '{sel: 2'd1, addr: 12'h010, wdata: 32'h0BAD_F00D, last: 1'b0};
        cmds[1] = '{sel: 2'd0, addr: 12'h011, wdata: 32'h0000_CAFE, last: 1'b1};
        busy_pat[0] = 0; busy_pat[1] = 0; busy_pat[2] = 1; busy_pat[3] = 0; busy_pat[4] = 0;
        busy_len = 5;
        busy_rest = 1'b0;
        run_batch(2, 12);
        check("gl_n_we",     64'(n_we), 64'd2);
        check("gl_we0_cyc",  64'(we_cyc[0]), 64'd6);
        check("gl_we1_cyc",  64'(we_cyc[1]), 64'd7);
        check_we("gl_we1", 1);
        check("gl_err_last", 64'(err_last), 64'd0);
        check("gl_cfg_error", 64'(cfg_error), 64'd0);
        check("gl_done_cyc", 64'(done_cyc), 64'd8);
        check("gl_write_count", 64'(write_count), 64'd2);

        // ---------------- reset after first of four writes ----------------
        cmds[0] = '{sel: 2'd2, addr: 12'h0F0, wdata: 32'h1111_0001, last: 1'b0};
        cmds[1] = '{sel: 2'd2, addr: 12'h0F1, wdata: 32'h1111_0002, last: 1'b0};
        cmds[2] = '{sel: 2'd2, addr: 12'h0F2, wdata: 32'h1111_0003, last: 1'b0};
        cmds[3] = '{sel: 2'd2, addr: 12'h0F3, wdata: 32'h1111_0004, last: 1'b1};
        busy_len = 0;
        run_batch(4, 4);
        check("mr_we_before",    64'(cfg_we), 64'd1);
        check("mr_addr_before",  64'(cfg_addr), 64'h0F0);
        check("mr_count_before", 64'(write_count), 64'd1);
        rst_n = 1'b0;
        cmd_if.valid = 1'b0;
        #1;
        check("mr_cfg_we",      64'(cfg_we), 64'd0);
        check("mr_write_count", 64'(write_count), 64'd0);
        check("mr_cfg_active",  64'(cfg_active), 64'd0);
        check("mr_cmd_ready",   64'(cmd_if.ready), 64'd0);
        check("mr_cfg_fields",  64'({cfg_sel, cfg_addr, cfg_wdata}), 64'd0);
        check("mr_done_err",    64'({cfg_done, cfg_error}), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        we_after = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cfg_we || cfg_active) we_after++;
            @(posedge clk); #1;
        end
        check("mr_no_more_writes", 64'(we_after), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
